// File: rtl/ddr_mgr_pkg.sv
// ---------------------------------------------------------------------------
// ddr_mgr_pkg
// Shared types and constants for the DDR manager: transfer FSM states, the
// requester-select encoding, and default row/burst geometry shared by the
// transfer arbiter, the line-buffer engine and the preload engine.
// ---------------------------------------------------------------------------
package ddr_mgr_pkg;

  // Default row geometry: 32 bursts of 4 words cover one 128-word row.
  localparam int DEF_BURSTS_PER_ROW = 32;
  localparam int DEF_COL_STEP       = 4;
  localparam int DEF_STARVE_MAX     = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } xfr_state_e;

  typedef enum logic {
    SEL_RD = 1'b0,
    SEL_WR = 1'b1
  } xfr_sel_e;

  // Display reads win ties so the scanout never underruns, unless the
  // pending write has already been passed over too many times.
  function automatic xfr_sel_e ddr_xfr_prio(input logic rd_req,
                                            input logic wr_req,
                                            input logic starve_hit);
    if (wr_req && (!rd_req || starve_hit)) begin
      return SEL_WR;
    end
    return SEL_RD;
  endfunction

endpackage

// File: rtl/ddr_xfr_arb.sv
// ---------------------------------------------------------------------------
// ddr_xfr_arb
// Arbitrates the MIG user command port between the display line-read engine
// and the Picoblaze preload/write engine. One requester is granted at a time;
// its row is split into BURSTS_PER_ROW burst commands issued one by one over
// a valid/ready handshake, each waiting for burst_done before the next.
//
// Ports:
//   clk, rst            memory user clock, synchronous active-high reset
//   mig_init_done       MIG calibration done; nothing is granted before it
//   rd_req/rd_row       display read request (level) and row
//   rd_gnt/rd_done      read in progress / one-cycle completion pulse
//   wr_req/wr_row       write request (level) and row
//   wr_gnt/wr_done      write in progress / one-cycle completion pulse
//   cmd_valid/cmd_ready burst command handshake
//   cmd_rd              1 = read burst, 0 = write burst
//   cmd_addr            {row, col}
//   burst_done          datapath pulse: current burst data finished
//   busy                FSM not idle
// ---------------------------------------------------------------------------
module ddr_xfr_arb
  import ddr_mgr_pkg::*;
#(
  parameter int ROW_W          = 10,
  parameter int COL_W          = 9,
  parameter int BURSTS_PER_ROW = DEF_BURSTS_PER_ROW,
  parameter int COL_STEP       = DEF_COL_STEP,
  parameter int STARVE_MAX     = DEF_STARVE_MAX
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mig_init_done,
  input  logic                   rd_req,
  input  logic [ROW_W-1:0]       rd_row,
  output logic                   rd_gnt,
  output logic                   rd_done,
  input  logic                   wr_req,
  input  logic [ROW_W-1:0]       wr_row,
  output logic                   wr_gnt,
  output logic                   wr_done,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic                   cmd_rd,
  output logic [ROW_W+COL_W-1:0] cmd_addr,
  input  logic                   burst_done,
  output logic                   busy
);

  localparam int IDX_W = (BURSTS_PER_ROW > 1) ? $clog2(BURSTS_PER_ROW) : 1;
  localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURSTS_PER_ROW - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

  xfr_state_e       state_q, state_d;
  xfr_sel_e         sel_q, sel_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] burst_idx_q, burst_idx_d;
  logic [STV_W-1:0] starve_cnt_q, starve_cnt_d;
  xfr_sel_e         pick;
  logic             xfer_active;
  logic [COL_W-1:0] col;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sel_q        <= SEL_RD;
      row_q        <= '0;
      burst_idx_q  <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      row_q        <= row_d;
      burst_idx_q  <= burst_idx_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign pick = ddr_xfr_prio(rd_req, wr_req, starve_cnt_q >= STV_MAX);

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    row_d        = row_q;
    burst_idx_d  = burst_idx_q;
    starve_cnt_d = starve_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (mig_init_done && (rd_req || wr_req)) begin
          sel_d       = pick;
          row_d       = (pick == SEL_WR) ? wr_row : rd_row;
          burst_idx_d = '0;
          state_d     = S_CMD;
          // A read grant only counts against the writer if it was waiting.
          if (pick == SEL_WR || !wr_req) begin
            starve_cnt_d = '0;
          end else if (starve_cnt_q < STV_MAX) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end
      end
      S_CMD: begin
        if (cmd_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (burst_done) begin
          if (burst_idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            burst_idx_d = burst_idx_q + 1'b1;
            state_d     = S_CMD;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode the registered state so they are glitch-free and all
  // fall to zero with the state on reset.
  assign xfer_active = (state_q == S_CMD) || (state_q == S_WAIT);
  assign col         = COL_W'(burst_idx_q) * COL_W'(COL_STEP);

  assign busy      = (state_q != S_IDLE);
  assign cmd_valid = (state_q == S_CMD);
  assign cmd_rd    = (state_q == S_CMD) && (sel_q == SEL_RD);
  assign cmd_addr  = {row_q, col};
  assign rd_gnt    = xfer_active && (sel_q == SEL_RD);
  assign wr_gnt    = xfer_active && (sel_q == SEL_WR);
  assign rd_done   = (state_q == S_DONE) && (sel_q == SEL_RD);
  assign wr_done   = (state_q == S_DONE) && (sel_q == SEL_WR);

endmodule

// File: tb/tb_ddr_xfr_arb.sv
// ---------------------------------------------------------------------------
// tb_ddr_xfr_arb
// Drives ddr_xfr_arb with directed scenarios plus randomized request traffic
// and compares every granted transfer against a transaction-level model of
// the arbitration and address rules.
// ---------------------------------------------------------------------------
module tb_ddr_xfr_arb;

  localparam int BURSTS   = 32;
  localparam int COLSTEP  = 4;
  localparam int STARVEMX = 4;

  logic        clk;
  logic        rst;
  logic        mig_init_done;
  logic        rd_req;
  logic [9:0]  rd_row;
  logic        rd_gnt;
  logic        rd_done;
  logic        wr_req;
  logic [9:0]  wr_row;
  logic        wr_gnt;
  logic        wr_done;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rd;
  logic [18:0] cmd_addr;
  logic        burst_done;
  logic        busy;

  int checkCount = 0;
  int passCount  = 0;
  int rdDoneCnt  = 0;
  int wrDoneCnt  = 0;
  int modelStarve = 0;
  bit gntOverlap = 0;

  ddr_xfr_arb dut (
    .clk           (clk),
    .rst           (rst),
    .mig_init_done (mig_init_done),
    .rd_req        (rd_req),
    .rd_row        (rd_row),
    .rd_gnt        (rd_gnt),
    .rd_done       (rd_done),
    .wr_req        (wr_req),
    .wr_row        (wr_row),
    .wr_gnt        (wr_gnt),
    .wr_done       (wr_done),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_rd        (cmd_rd),
    .cmd_addr      (cmd_addr),
    .burst_done    (burst_done),
    .busy          (busy)
  );

  // Free-running 100 MHz memory clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the run ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      passCount++;
    end
  endtask

  // Advance one clock and sample 1 ns after the edge; tracks done pulses
  // and any overlap of the two grants.
  task automatic stepCycle();
    @(posedge clk);
    #1;
    if (rd_gnt && wr_gnt) gntOverlap = 1;
    if (rd_done) rdDoneCnt++;
    if (wr_done) wrDoneCnt++;
  endtask

  // Reference arbitration: read wins ties unless the writer has been passed
  // over STARVEMX times in a row.
  function automatic bit modelPickRd(input bit r, input bit w);
    if (r && w) return (modelStarve < STARVEMX);
    return r;
  endfunction

  task automatic modelGrant(input bit isRd, input bit wPending);
    if (!isRd || !wPending) modelStarve = 0;
    else if (modelStarve < STARVEMX) modelStarve++;
  endtask

  // Runs one whole transfer from the grant edge to the following IDLE cycle,
  // playing the MIG/datapath side with random stalls and latencies.
  task automatic applyStimulus(input bit expRd, input int expRow, input int firstStall,
                               input bit dropAfterFirst, input bit dropOnDone, input int abortAt);
    int expAddr;
    int stall;
    int lat;
    int rdStart;
    int wrStart;
    bit wobble;
    rdStart = rdDoneCnt;
    wrStart = wrDoneCnt;
    stepCycle();
    checkOutput("grantOwn", expRd ? rd_gnt : wr_gnt, 1);
    checkOutput("grantOther", expRd ? wr_gnt : rd_gnt, 0);
    for (int b = 0; b < BURSTS; b++) begin
      expAddr = expRow * 512 + b * COLSTEP;
      if (b == abortAt) begin
        rst = 1'b1;
        rd_req = 1'b0;
        wr_req = 1'b0;
        stepCycle();
        checkOutput("abortOutputs",
                    {rd_gnt, wr_gnt, rd_done, wr_done, cmd_valid, cmd_rd, busy, cmd_addr}, 0);
        rst = 1'b0;
        modelStarve = 0;
        checkOutput("abortNoDone", (rdDoneCnt - rdStart) + (wrDoneCnt - wrStart), 0);
        return;
      end
      stall = (b == 0) ? firstStall : $urandom_range(0, 2);
      cmd_ready = 1'b0;
      wobble = 0;
      for (int s = 0; s < stall; s++) begin
        burst_done = 1'($urandom_range(0, 1));
        stepCycle();
        burst_done = 1'b0;
        if (cmd_valid !== 1'b1 || cmd_addr !== 19'(expAddr)) wobble = 1;
      end
      checkOutput("stallStable", wobble, 0);
      checkOutput("cmdValid", cmd_valid, 1);
      checkOutput("cmdAddr", cmd_addr, expAddr);
      checkOutput("cmdRd", cmd_rd, expRd);
      cmd_ready = 1'b1;
      stepCycle();
      cmd_ready = 1'($urandom_range(0, 1));
      if (dropAfterFirst && b == 0) begin
        if (expRd) rd_req = 1'b0;
        else wr_req = 1'b0;
      end
      checkOutput("validDrops", cmd_valid, 0);
      lat = $urandom_range(0, 3);
      for (int w = 0; w < lat; w++) stepCycle();
      burst_done = 1'b1;
      stepCycle();
      burst_done = 1'b0;
      cmd_ready = 1'b0;
    end
    checkOutput("donePulse", expRd ? rd_done : wr_done, 1);
    checkOutput("gntAtDone", {rd_gnt, wr_gnt}, 0);
    if (dropOnDone) begin
      if (expRd) rd_req = 1'b0;
      else wr_req = 1'b0;
    end
    stepCycle();
    checkOutput("idleAfterDone", {busy, rd_done, wr_done}, 0);
    checkOutput("doneCount", expRd ? (rdDoneCnt - rdStart) : (wrDoneCnt - wrStart), 1);
    checkOutput("otherDoneCount", expRd ? (wrDoneCnt - wrStart) : (rdDoneCnt - rdStart), 0);
  endtask

  // Main scenario sequence.
  initial begin
    bit sawActivity;
    bit pickRd;
    bit wPend;
    rst = 1'b1;
    mig_init_done = 1'b0;
    rd_req = 1'b0;
    wr_req = 1'b0;
    rd_row = '0;
    wr_row = '0;
    cmd_ready = 1'b0;
    burst_done = 1'b0;
    repeat (3) stepCycle();
    checkOutput("resetOutputs",
                {rd_gnt, wr_gnt, rd_done, wr_done, cmd_valid, cmd_rd, busy, cmd_addr}, 0);
    rst = 1'b0;

    // No grant before MIG init, then first read with a 10-cycle stall.
    rd_req = 1'b1;
    rd_row = 10'h005;
    sawActivity = 0;
    for (int i = 0; i < 100; i++) begin
      stepCycle();
      if (cmd_valid || rd_gnt || busy) sawActivity = 1;
    end
    checkOutput("initGate", sawActivity, 0);
    mig_init_done = 1'b1;
    modelGrant(1, 0);
    applyStimulus(1, 5, 10, 0, 1, -1);

    // Lone write.
    wr_req = 1'b1;
    wr_row = 10'($urandom);
    modelGrant(0, 1);
    applyStimulus(0, wr_row, 1, 0, 1, -1);

    // Both requests held: reads until the writer is starved, then a write.
    rd_req = 1'b1;
    wr_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rd_row = 10'($urandom);
      wr_row = 10'($urandom);
      pickRd = modelPickRd(1, 1);
      modelGrant(pickRd, 1);
      applyStimulus(pickRd, pickRd ? rd_row : wr_row, 0, 0, 0, -1);
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    stepCycle();

    // Reset during the 10th read burst, then a fresh read restarts at col 0.
    rd_req = 1'b1;
    rd_row = 10'h155;
    modelGrant(1, 0);
    applyStimulus(1, rd_row, 0, 0, 0, 9);
    rd_req = 1'b1;
    rd_row = 10'h2AA;
    modelGrant(1, 0);
    applyStimulus(1, rd_row, 2, 0, 1, -1);

    // Request dropped after the first accept still completes; no regrant.
    rd_req = 1'b1;
    rd_row = 10'h3C1;
    modelGrant(1, 0);
    applyStimulus(1, rd_row, 0, 1, 1, -1);
    sawActivity = 0;
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      if (busy || rd_gnt || wr_gnt) sawActivity = 1;
    end
    checkOutput("noRegrant", sawActivity, 0);

    // Random traffic: requesters raise at will and drop on done.
    for (int i = 0; i < 20; i++) begin
      if (!rd_req && $urandom_range(0, 1) == 1) begin
        rd_req = 1'b1;
        rd_row = 10'($urandom);
      end
      if (!wr_req && $urandom_range(0, 1) == 1) begin
        wr_req = 1'b1;
        wr_row = 10'($urandom);
      end
      if (!rd_req && !wr_req) begin
        rd_req = 1'b1;
        rd_row = 10'($urandom);
      end
      wPend = wr_req;
      pickRd = modelPickRd(rd_req, wr_req);
      modelGrant(pickRd, wPend);
      applyStimulus(pickRd, pickRd ? rd_row : wr_row, $urandom_range(0, 3), 0, 1, -1);
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    stepCycle();

    checkOutput("gntExclusive", gntOverlap, 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
